mul_cdb_buffer: RTL and testbench
=================================

# mul_cdb_buffer

Result buffer between the pipelined multiplier and the CDB arbiter. Captures each multiplier completion (value, destination PRF index, ROB index, PC) into a small FIFO and holds it until the CDB grants the multiply unit. Issues credits back to the multiply RS so that no result is ever lost while the CDB is busy. Handles branch squash, including discarding results still in flight inside the multiplier pipeline.

## Interface
- XLEN, 32, data width
- PRF_LEN, 6, physical register index width
- ROB_LEN, 5, ROB index width
- DEPTH, 4, FIFO entries (≥1)
- PIPE_LAT, 8, multiplier issue-to-valid latency in cycles (informational; credit logic does not depend on it)
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- mul_issue  in  1  RS starts a multiply this cycle
- mul_valid  in  1  multiplier result valid this cycle
- mul_value  in  XLEN  result value
- mul_prf_idx  in  PRF_LEN  destination preg
- mul_rob_idx  in  ROB_LEN  ROB entry
- mul_PC  in  XLEN  instruction PC
- cdb_grant  in  1  CDB accepts the head entry this cycle
- squash  in  1  branch mispredict flush
- mul_issue_ok  out  1  RS may issue a multiply this cycle
- buf_valid  out  1  head entry valid
- buf_value  out  XLEN  head value
- buf_prf_idx  out  PRF_LEN  head preg
- buf_rob_idx  out  ROB_LEN  head ROB index
- buf_PC  out  XLEN  head PC
- buf_overflow  out  1  sticky error: push into full FIFO without pop

## Operation
- State: circular FIFO (head ptr, tail ptr, count 0..DEPTH), inflight counter (ops issued, not yet returned, not squashed), drop_cnt (squashed ops still in the multiplier). Counters sized for DEPTH+PIPE_LAT+1.
- Credit: mul_issue_ok = (count + inflight) < DEPTH, computed from registered state only. mul_issue while mul_issue_ok=0 is a protocol violation by the RS and is not checked.
- Arrival (mul_valid=1, no squash): if drop_cnt>0, result discarded, drop_cnt−1; else entry pushed at tail, inflight−1.
- Issue (mul_issue=1, no squash): inflight+1. Issue and arrival in the same cycle: inflight unchanged.
- Pop: cdb_grant=1 and buf_valid=1 advance head, count−1. cdb_grant with buf_valid=0 is ignored.
- Push and pop in the same cycle: both take effect; count unchanged; legal when full.
- Push while count==DEPTH and no pop: entry dropped, buf_overflow set to 1 until reset.
- Squash (highest priority): FIFO emptied (count=0, head=tail); arrival in that cycle discarded; inflight←0; drop_cnt←drop_cnt+inflight+mul_issue−mul_valid. A mul_issue in the squash cycle is counted as a doomed op, because the multiplier still starts it.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Head outputs are driven from FIFO storage at head. They are zero whenever buf_valid=0.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert by the system): count, inflight, drop_cnt, pointers, buf_overflow = 0. All buf_* = 0. mul_issue_ok = 1. Reset mid-operation discards all entries and in-flight bookkeeping.
- Push-to-visible latency is 1 cycle: mul_valid at edge t gives buf_valid=1 after edge t (the next cycle). There is no same-cycle bypass.
- End-to-end: an issue in cycle t gives mul_valid in cycle t+PIPE_LAT, and buf_valid in cycle t+PIPE_LAT+1.
- Throughput is one push and one pop per cycle.
- Credit updates take 1 cycle: an issue in cycle t lowers mul_issue_ok starting in cycle t+1 if the limit is reached.

## Test plan
- Single op: reset, issue once with value 0x0000_0006, prf 3, rob 7, PC 0x100. mul_valid arrives 8 cycles later -> buf_valid=1 the next cycle with those fields. cdb_grant -> buf_valid=0, mul_issue_ok=1.
- Credit limit, DEPTH=4, cdb_grant held 0: issue on 4 consecutive cycles -> mul_issue_ok=0 from the cycle after the 4th issue. All 4 results are buffered in order. Then 4 grants -> 4 pops in issue order, mul_issue_ok=1 again.
- Simultaneous push/pop at full: 4 entries buffered, grant on the same cycle a new valid arrives -> count stays 4, order preserved, buf_overflow=0.
- Squash with 3 in flight plus an issue in the squash cycle -> FIFO empty, drop_cnt=4. The next 4 mul_valid pulses are discarded with buf_valid=0. A fresh op issued afterward is captured normally.
- Squash in the same cycle as an arrival (inflight 2 → drop_cnt=1): that arrival is not buffered, and exactly 1 later arrival is dropped.
- Reset mid-run: 2 entries buffered and 3 in flight, pull reset low -> all outputs 0 immediately, mul_issue_ok=1. buf_overflow is cleared after a forced overflow.

Source files
------------

// File: rtl/mul_cdb_buffer.sv
// Result buffer between the pipelined multiplier and the CDB arbiter: a small FIFO with
// credit return to the multiply RS, and squash handling for results still in the multiplier.
module mul_cdb_buffer #(
    parameter int XLEN     = 32,
    parameter int PRF_LEN  = 6,
    parameter int ROB_LEN  = 5,
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mul_issue,
    input  logic               mul_valid,
    input  logic [XLEN-1:0]    mul_value,
    input  logic [PRF_LEN-1:0] mul_prf_idx,
    input  logic [ROB_LEN-1:0] mul_rob_idx,
    input  logic [XLEN-1:0]    mul_PC,
    input  logic               cdb_grant,
    input  logic               squash,
    output logic               mul_issue_ok,
    output logic               buf_valid,
    output logic [XLEN-1:0]    buf_value,
    output logic [PRF_LEN-1:0] buf_prf_idx,
    output logic [ROB_LEN-1:0] buf_rob_idx,
    output logic [XLEN-1:0]    buf_PC,
    output logic               buf_overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + PIPE_LAT + 2);

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    pc;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_e;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, inflight, drop_cnt;
    logic            overflow_q;

    logic            arrive, drop_arrival, push_req, push, pop, ovf_evt;
    logic            inflight_dec;
    logic [CW:0]     squash_sum;
    logic [CW:0]     squash_drop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Arrival classification; squash overrides everything in its cycle.
    always_comb begin
        arrive       = mul_valid & ~squash;
        drop_arrival = arrive & (drop_cnt != '0);
        push_req     = arrive & ~drop_arrival;
        pop          = cdb_grant & (count != '0) & ~squash;
        push         = push_req & ((count != CW'(DEPTH)) | pop);
        ovf_evt      = push_req & (count == CW'(DEPTH)) & ~pop;
        inflight_dec = push_req & (inflight != '0);
    end

    // Ops still inside the multiplier after a squash: everything outstanding plus a
    // same-cycle issue, minus one that surfaces during the squash cycle itself.
    always_comb begin
        squash_sum  = {1'b0, drop_cnt} + {1'b0, inflight} + (CW+1)'(mul_issue);
        squash_drop = squash_sum;
        if (mul_valid && squash_sum != '0) squash_drop = squash_sum - (CW+1)'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            inflight   <= '0;
            drop_cnt   <= '0;
            overflow_q <= 1'b0;
        end else if (squash) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            inflight   <= '0;
            drop_cnt   <= CW'(squash_drop);
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(mul_issue) - CW'(inflight_dec);
            if (drop_arrival) drop_cnt <= drop_cnt - CW'(1);
            if (ovf_evt)      overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head outputs are gated by count.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= '{value: mul_value, prf_idx: mul_prf_idx,
                                 rob_idx: mul_rob_idx, pc: mul_PC};
    end

    always_comb begin
        head_e       = mem[head];
        buf_valid    = (count != '0);
        buf_value    = buf_valid ? head_e.value   : '0;
        buf_prf_idx  = buf_valid ? head_e.prf_idx : '0;
        buf_rob_idx  = buf_valid ? head_e.rob_idx : '0;
        buf_PC       = buf_valid ? head_e.pc      : '0;
        buf_overflow = overflow_q;
        mul_issue_ok = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    end

endmodule

// File: tb/tb_mul_cdb_buffer.sv
// Directed bench for mul_cdb_buffer: one linear sequence of steps, each checked by an
// immediate assertion against hand-computed values.
module tb_mul_cdb_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        mul_issue, mul_valid, cdb_grant, squash;
    logic [31:0] mul_value, mul_PC;
    logic [5:0]  mul_prf_idx;
    logic [4:0]  mul_rob_idx;
    logic        mul_issue_ok, buf_valid, buf_overflow;
    logic [31:0] buf_value, buf_PC;
    logic [5:0]  buf_prf_idx;
    logic [4:0]  buf_rob_idx;

    int vectors = 0;
    int miscompares = 0;

    mul_cdb_buffer #(.XLEN(32), .PRF_LEN(6), .ROB_LEN(5), .DEPTH(4), .PIPE_LAT(8)) dut (
        .clock(clock), .reset(reset),
        .mul_issue(mul_issue), .mul_valid(mul_valid), .mul_value(mul_value),
        .mul_prf_idx(mul_prf_idx), .mul_rob_idx(mul_rob_idx), .mul_PC(mul_PC),
        .cdb_grant(cdb_grant), .squash(squash),
        .mul_issue_ok(mul_issue_ok), .buf_valid(buf_valid), .buf_value(buf_value),
        .buf_prf_idx(buf_prf_idx), .buf_rob_idx(buf_rob_idx), .buf_PC(buf_PC),
        .buf_overflow(buf_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Fields of a result are derived from its value so a head check covers all four.
    task automatic chk_head(input string tag, input logic [31:0] v);
        logic [31:0] vv;
        vv = v;
        chk({tag, ".valid"}, 32'(buf_valid), 32'd1);
        chk({tag, ".value"}, buf_value, vv);
        chk({tag, ".prf"},   32'(buf_prf_idx), 32'(vv[5:0] ^ 6'h15));
        chk({tag, ".rob"},   32'(buf_rob_idx), 32'(vv[4:0]));
        chk({tag, ".pc"},    buf_PC, vv + 32'h1000);
    endtask

    task automatic clear_inputs();
        mul_issue = 0; mul_valid = 0; cdb_grant = 0; squash = 0;
        mul_value = '0; mul_prf_idx = '0; mul_rob_idx = '0; mul_PC = '0;
    endtask

    // Inputs are applied for exactly one rising edge; outputs are sampled 1 time unit after it.
    task automatic cyc(input logic iss, input logic vld, input logic [31:0] v,
                       input logic gnt, input logic sq);
        logic [31:0] vv;
        vv = v;
        mul_issue = iss; mul_valid = vld; cdb_grant = gnt; squash = sq;
        mul_value = vv; mul_prf_idx = vv[5:0] ^ 6'h15; mul_rob_idx = vv[4:0];
        mul_PC = vv + 32'h1000;
        @(posedge clock); #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        #1;
        chk("rst.valid", 32'(buf_valid), 0);
        chk("rst.value", buf_value, 0);
        chk("rst.ok", 32'(mul_issue_ok), 1);
        chk("rst.ovf", 32'(buf_overflow), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1;

        // Single op: issue, result 8 cycles later, visible the cycle after.
        cyc(1, 0, 0, 0, 0);
        chk("t1.ok_after_issue", 32'(mul_issue_ok), 1);
        idle(7);
        chk("t1.not_yet", 32'(buf_valid), 0);
        // value 6 -> prf 6^0x15 derived; check explicit spec fields separately below
        mul_issue = 0; mul_valid = 1; mul_value = 32'h6; mul_prf_idx = 6'd3;
        mul_rob_idx = 5'd7; mul_PC = 32'h100;
        @(posedge clock); #1;
        clear_inputs();
        chk("t1.valid", 32'(buf_valid), 1);
        chk("t1.value", buf_value, 32'h6);
        chk("t1.prf", 32'(buf_prf_idx), 3);
        chk("t1.rob", 32'(buf_rob_idx), 7);
        chk("t1.pc", buf_PC, 32'h100);
        cyc(0, 0, 0, 1, 0);
        chk("t1.popped", 32'(buf_valid), 0);
        chk("t1.zero_val", buf_value, 0);
        chk("t1.ok", 32'(mul_issue_ok), 1);

        // Credit limit: 4 issues, no grants.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t2.ok_after3", 32'(mul_issue_ok), 1);
        cyc(1, 0, 0, 0, 0);
        chk("t2.ok_after4", 32'(mul_issue_ok), 0);
        idle(4);
        cyc(0, 1, 32'hA0, 0, 0);
        chk_head("t2.first", 32'hA0);
        cyc(0, 1, 32'hA1, 0, 0);
        cyc(0, 1, 32'hA2, 0, 0);
        cyc(0, 1, 32'hA3, 0, 0);
        chk_head("t2.full_head", 32'hA0);
        chk("t2.ok_full", 32'(mul_issue_ok), 0);

        // Push and pop in the same cycle while full.
        cyc(0, 1, 32'hA4, 1, 0);
        chk_head("t3.head", 32'hA1);
        chk("t3.ovf", 32'(buf_overflow), 0);
        cyc(0, 0, 0, 1, 0);
        chk_head("t3.pop1", 32'hA2);
        cyc(0, 0, 0, 1, 0);
        chk_head("t3.pop2", 32'hA3);
        cyc(0, 0, 0, 1, 0);
        chk_head("t3.pop3", 32'hA4);
        chk("t3.ok_count1", 32'(mul_issue_ok), 1);
        cyc(0, 0, 0, 1, 0);
        chk("t3.empty", 32'(buf_valid), 0);
        cyc(0, 0, 0, 1, 0);
        chk("t3.grant_empty", 32'(buf_valid), 0);

        // Squash with 3 in flight plus an issue in the squash cycle: 4 doomed ops.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        chk("t4.empty", 32'(buf_valid), 0);
        chk("t4.ok", 32'(mul_issue_ok), 1);
        cyc(0, 1, 32'hD0, 0, 0);
        chk("t4.drop0", 32'(buf_valid), 0);
        cyc(0, 1, 32'hD1, 0, 0);
        chk("t4.drop1", 32'(buf_valid), 0);
        cyc(0, 1, 32'hD2, 0, 0);
        chk("t4.drop2", 32'(buf_valid), 0);
        cyc(0, 1, 32'hD3, 0, 0);
        chk("t4.drop3", 32'(buf_valid), 0);
        cyc(1, 0, 0, 0, 0);
        idle(3);
        cyc(0, 1, 32'hE0, 0, 0);
        chk_head("t4.fresh", 32'hE0);
        cyc(0, 0, 0, 1, 0);
        chk("t4.pop", 32'(buf_valid), 0);

        // Squash coinciding with an arrival, inflight 2 -> exactly one later drop.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hF0, 0, 1);
        chk("t5.sq_arrival", 32'(buf_valid), 0);
        cyc(0, 1, 32'hF1, 0, 0);
        chk("t5.dropped", 32'(buf_valid), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hF2, 0, 0);
        chk_head("t5.kept", 32'hF2);
        cyc(0, 0, 0, 1, 0);
        chk("t5.pop", 32'(buf_valid), 0);

        // Forced overflow, then reset mid-run with entries buffered and ops in flight.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hB0, 0, 0);
        cyc(0, 1, 32'hB1, 0, 0);
        cyc(0, 1, 32'hB2, 0, 0);
        cyc(0, 1, 32'hB3, 0, 0);
        chk("t6.no_ovf_yet", 32'(buf_overflow), 0);
        cyc(0, 1, 32'hB4, 0, 0);
        chk("t6.ovf", 32'(buf_overflow), 1);
        chk_head("t6.head_kept", 32'hB0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk_head("t6.two_left", 32'hB2);
        chk("t6.ovf_sticky", 32'(buf_overflow), 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t6.ok_low", 32'(mul_issue_ok), 0);
        reset = 0;
        #1;
        chk("t6.rst_valid", 32'(buf_valid), 0);
        chk("t6.rst_value", buf_value, 0);
        chk("t6.rst_pc", buf_PC, 0);
        chk("t6.rst_ok", 32'(mul_issue_ok), 1);
        chk("t6.rst_ovf", 32'(buf_overflow), 0);
        @(posedge clock); #1 reset = 1;
        // Bookkeeping is clean: the next arrival is captured, not dropped.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hC0, 0, 0);
        chk_head("t6.after_rst", 32'hC0);
        chk("t6.ok_after", 32'(mul_issue_ok), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
